// File: rtl/cam_emu.sv
`default_nettype none
// ============================================================================
//  Module      : cam_emu
//  Description : Camera sensor emulator. Produces a pixel clock at clk/2 with
//                an 8-bit YUYV byte stream framed by vs/href. Frames run
//                VSYNC -> VBACK -> ACTIVE -> VFRONT and repeat while enable
//                is high. Four test patterns are selected by mode and latched
//                at each frame start.
//                Optional macro CAM_EMU_FRAME_CNT_EN enables the completed-frame
//                counter (frame_cnt) and the frame-count pattern (mode 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module cam_emu #(
   parameter int IMAGE_WIDTH  = 640,
   parameter int IMAGE_HEIGHT = 480,
   parameter int H_BLANK      = 144,
   parameter int V_SYNC       = 3,
   parameter int V_BACK       = 17,
   parameter int V_FRONT      = 10,
   parameter int LINE_COL     = 320
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        enable,
   input  logic [1:0]  mode,
   output logic        pclk,
   output logic        href,
   output logic        vs,
   output logic [7:0]  data,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] frame_cnt
);

   // Line length is counted in bytes: two bytes (Y + chroma) per pixel.
   localparam int c_line_bytes = 2 * (IMAGE_WIDTH + H_BLANK);
   localparam int c_max_a      = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
   localparam int c_max_b      = (IMAGE_HEIGHT > V_FRONT) ? IMAGE_HEIGHT : V_FRONT;
   localparam int c_max_lines  = (c_max_a > c_max_b) ? c_max_a : c_max_b;
   localparam int c_bw         = $clog2(c_line_bytes);
   localparam int c_lw         = $clog2(c_max_lines + 1);

   localparam logic [c_bw-1:0] c_byte_last = c_bw'(c_line_bytes - 1);
   localparam logic [c_bw-1:0] c_href_end  = c_bw'(2 * IMAGE_WIDTH);

   localparam logic [2:0] c_st_idle   = 3'd0;
   localparam logic [2:0] c_st_vsync  = 3'd1;
   localparam logic [2:0] c_st_vback  = 3'd2;
   localparam logic [2:0] c_st_active = 3'd3;
   localparam logic [2:0] c_st_vfront = 3'd4;

   logic            r_pclk;
   logic [2:0]      r_state;
   logic [2:0]      w_next_state;
   logic [c_bw-1:0] r_byte;
   logic [c_lw-1:0] r_line;
   logic [c_lw-1:0] w_line_last;
   logic [1:0]      r_mode;
   logic            r_frame_done;
   logic            w_update;
   logic            w_line_end;
   logic            w_phase_end;
   logic            w_frame_end;
   logic            w_frame_start;
   logic [15:0]     w_frame_cnt;
   logic [15:0]     w_col;
   logic [7:0]      w_y;

   // Free-running pixel clock; everything else moves on its falling transition.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) r_pclk <= 1'b0;
      else        r_pclk <= ~r_pclk;
   end

   assign w_update = r_pclk;
   assign pclk     = r_pclk;

   // Last line index of the phase the FSM is currently in.
   always_comb begin
      w_line_last = '0;
      case (r_state)
         c_st_vsync:  w_line_last = c_lw'(V_SYNC - 1);
         c_st_vback:  w_line_last = c_lw'(V_BACK - 1);
         c_st_active: w_line_last = c_lw'(IMAGE_HEIGHT - 1);
         c_st_vfront: w_line_last = c_lw'(V_FRONT - 1);
         default:     w_line_last = '0;
      endcase
   end

   assign w_line_end    = (r_byte == c_byte_last);
   assign w_phase_end   = w_line_end && (r_line == w_line_last);
   assign w_frame_end   = w_update && (r_state == c_st_vfront) && w_phase_end;
   // VSYNC is only entered from IDLE or VFRONT, so any entry is a frame start.
   assign w_frame_start = (w_next_state == c_st_vsync) && (r_state != c_st_vsync);

   // FSM state register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) r_state <= c_st_idle;
      else        r_state <= w_next_state;
   end

   // FSM next-state: phases advance at the last byte of their last line.
   always_comb begin
      w_next_state = r_state;
      if (w_update) begin
         case (r_state)
            c_st_idle:   if (enable)      w_next_state = c_st_vsync;
            c_st_vsync:  if (w_phase_end) w_next_state = c_st_vback;
            c_st_vback:  if (w_phase_end) w_next_state = c_st_active;
            c_st_active: if (w_phase_end) w_next_state = c_st_vfront;
            c_st_vfront: if (w_phase_end) w_next_state = enable ? c_st_vsync : c_st_idle;
            default:                      w_next_state = c_st_idle;
         endcase
      end
   end

   // FSM outputs: sync strobes decoded from state and byte position.
   always_comb begin
      busy = (r_state != c_st_idle);
      vs   = (r_state == c_st_vsync);
      href = (r_state == c_st_active) && (r_byte < c_href_end);
   end

   // Byte/line counters and the per-frame mode latch.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_byte <= '0;
         r_line <= '0;
         r_mode <= 2'd0;
      end else if (w_update) begin
         if (w_frame_start) r_mode <= mode;
         if (r_state != c_st_idle) begin
            if (w_line_end) begin
               r_byte <= '0;
               r_line <= w_phase_end ? '0 : r_line + 1'b1;
            end else begin
               r_byte <= r_byte + 1'b1;
            end
         end
      end
   end

   // One-clk end-of-frame pulse; non-update cycles clear it.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) r_frame_done <= 1'b0;
      else        r_frame_done <= w_frame_end;
   end

   assign frame_done = r_frame_done;

`ifdef CAM_EMU_FRAME_CNT_EN
   logic [15:0] r_frame_cnt;

   // Completed-frame counter, wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)           r_frame_cnt <= 16'h0000;
      else if (w_frame_end) r_frame_cnt <= r_frame_cnt + 16'd1;
   end

   assign w_frame_cnt = r_frame_cnt;
`else
   assign w_frame_cnt = 16'h0000;
`endif

   assign frame_cnt = w_frame_cnt;
   assign w_col     = 16'(r_byte >> 1);

   // Pattern generator: luma from the latched mode, fixed mid-scale chroma.
   always_comb begin
      w_y = 8'h00;
      case (r_mode)
         2'd0:    w_y = w_col[7:0];
         2'd1:    w_y = w_col[6] ? 8'hEB : 8'h10;
         2'd2:    w_y = w_frame_cnt[7:0];
         default: w_y = (w_col == 16'(LINE_COL)) ? 8'hFF : 8'h00;
      endcase
      data = 8'h00;
      if (href) data = r_byte[0] ? 8'h80 : w_y;
   end

endmodule
`default_nettype wire

// File: tb/tb_cam_emu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cam_emu
//  Description : Scoreboard bench for cam_emu with reduced frame geometry.
//                A frame-position reference model pushes the expected output
//                word after every clock edge; a monitor pops and compares on
//                the opposite edge. Honours CAM_EMU_FRAME_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_emu;

   localparam int W     = 80;
   localparam int H     = 4;
   localparam int HB    = 8;
   localparam int VS_L  = 2;
   localparam int VB_L  = 2;
   localparam int VF_L  = 2;
   localparam int LC    = 70;
   localparam int LB    = 2 * (W + HB);
   localparam int LINES = VS_L + VB_L + H + VF_L;
   localparam int FB    = LB * LINES;

   logic        clk    = 1'b0;
   logic        n_rst  = 1'b0;
   logic        enable = 1'b0;
   logic [1:0]  mode   = 2'd0;
   logic        pclk;
   logic        href;
   logic        vs;
   logic [7:0]  data;
   logic        busy;
   logic        frame_done;
   logic [15:0] frame_cnt;

   cam_emu #(
      .IMAGE_WIDTH  (W),
      .IMAGE_HEIGHT (H),
      .H_BLANK      (HB),
      .V_SYNC       (VS_L),
      .V_BACK       (VB_L),
      .V_FRONT      (VF_L),
      .LINE_COL     (LC)
   ) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .enable     (enable),
      .mode       (mode),
      .pclk       (pclk),
      .href       (href),
      .vs         (vs),
      .data       (data),
      .busy       (busy),
      .frame_done (frame_done),
      .frame_cnt  (frame_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        pclk;
      logic        href;
      logic        vs;
      logic        busy;
      logic        fd;
      logic [7:0]  data;
      logic [15:0] fcnt;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   // Reference model state: position within the frame as one byte index.
   bit          m_ph   = 1'b0;
   bit          m_busy = 1'b0;
   bit          m_done = 1'b0;
   int          m_pos  = 0;
   logic [1:0]  m_mode = 2'd0;
   logic [15:0] m_fcnt = 16'h0000;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] y_of(input int c, input logic [1:0] md, input logic [15:0] fc);
      case (md)
         2'd0: return 8'(c % 256);
         2'd1: return (((c / 64) % 2) == 1) ? 8'hEB : 8'h10;
`ifdef CAM_EMU_FRAME_CNT_EN
         2'd2: return fc[7:0];
`else
         2'd2: return (fc == 16'hFFFF) ? 8'h00 : 8'h00;
`endif
         default: return (c == LC) ? 8'hFF : 8'h00;
      endcase
   endfunction

   function automatic exp_t expect_now();
      exp_t e;
      int   line;
      int   b;
      e.pclk = m_ph;
      e.busy = m_busy;
      e.fd   = m_done;
      e.fcnt = m_fcnt;
      e.vs   = 1'b0;
      e.href = 1'b0;
      e.data = 8'h00;
      if (m_busy) begin
         line = m_pos / LB;
         b    = m_pos % LB;
         e.vs = (line < VS_L);
         if (line >= VS_L + VB_L && line < VS_L + VB_L + H && b < 2 * W) begin
            e.href = 1'b1;
            e.data = ((b % 2) == 1) ? 8'h80 : y_of(b / 2, m_mode, m_fcnt);
         end
      end
      return e;
   endfunction

   // Reference model: advances one byte per pixel-clock falling transition.
   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         m_ph   = 1'b0;
         m_busy = 1'b0;
         m_done = 1'b0;
         m_pos  = 0;
         m_mode = 2'd0;
         m_fcnt = 16'h0000;
         exp_q.delete();
      end else begin
         m_done = 1'b0;
         if (m_ph) begin
            if (!m_busy) begin
               if (enable) begin
                  m_busy = 1'b1;
                  m_pos  = 0;
                  m_mode = mode;
               end
            end else if (m_pos == FB - 1) begin
               m_done = 1'b1;
`ifdef CAM_EMU_FRAME_CNT_EN
               m_fcnt = m_fcnt + 16'd1;
`endif
               if (enable) begin
                  m_pos  = 0;
                  m_mode = mode;
               end else begin
                  m_busy = 1'b0;
               end
            end else begin
               m_pos++;
            end
         end
         m_ph = !m_ph;
         exp_q.push_back(expect_now());
      end
   end

   // Monitor: compares every output against the queued expectation.
   always @(negedge clk) begin
      if (n_rst && exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("pclk",       16'(pclk),       16'(mon_e.pclk));
         chk("href",       16'(href),       16'(mon_e.href));
         chk("vs",         16'(vs),         16'(mon_e.vs));
         chk("busy",       16'(busy),       16'(mon_e.busy));
         chk("frame_done", 16'(frame_done), 16'(mon_e.fd));
         chk("data",       16'(data),       16'(mon_e.data));
         chk("frame_cnt",  frame_cnt,       mon_e.fcnt);
      end
   end

   task automatic run_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_pclk"},  16'(pclk),       16'h0);
      chk({tag, "_href"},  16'(href),       16'h0);
      chk({tag, "_vs"},    16'(vs),         16'h0);
      chk({tag, "_data"},  16'(data),       16'h0);
      chk({tag, "_busy"},  16'(busy),       16'h0);
      chk({tag, "_fdone"}, 16'(frame_done), 16'h0);
      chk({tag, "_fcnt"},  frame_cnt,       16'h0);
   endtask

   initial begin
      run_clks(3);
      chk_reset("reset_init");
      #2 n_rst = 1'b1;

      // Ramp frame, switched to bars mid-frame; bars must wait for next frame.
      @(negedge clk);
      enable = 1'b1;
      mode   = 2'd0;
      run_clks(FB);
      mode = 2'd1;
      run_clks(3 * FB);

      // Single-line pattern, then frame-count pattern over two frames.
      mode = 2'd3;
      run_clks(2 * FB);
      mode = 2'd2;
      run_clks(4 * FB);

      // Drop enable inside the active region; frame must finish, then idle.
      run_clks(2 * LB * (VS_L + VB_L + 1));
      enable = 1'b0;
      run_clks(3 * FB);

      // Restart and reset in the middle of an active line.
      enable = 1'b1;
      mode   = 2'd0;
      run_clks(2 * LB * (VS_L + VB_L + 2) + 40);
      #2 n_rst = 1'b0;
      #1 chk_reset("reset_mid");
      @(negedge clk);
      chk_reset("reset_hold");
      #2 n_rst = 1'b1;
      run_clks(2 * FB + 100);

      // Randomized enable/mode activity.
      for (int i = 0; i < 16; i++) begin
         mode   = 2'($urandom_range(0, 3));
         enable = ($urandom_range(0, 3) != 0);
         run_clks($urandom_range(50, 1500));
      end
      enable = 1'b0;
      run_clks(2 * FB + 10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
